// File: rtl/alu_arith_pkg.sv
// Shared types and constants for the ALU arithmetic unit (sequential multiplier).
package alu_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int unsigned MULT_WIDTH = 8;
  localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH);

endpackage

// File: rtl/mult_shift_add_step.sv
// One shift-and-add step: conditional add of multiplicand into the upper
// half, then shift {carry, accumulator, multiplier} right by one.
module mult_shift_add_step
  import alu_arith_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] acc_mplier_c
);

  logic [WIDTH:0] sum;

  // Carry-keeping add followed by the right shift; the shifted-out LSB is dropped.
  always_comb begin
    sum = {1'b0, acc};
    if (mplier[0]) begin
      sum = sum + {1'b0, mcand};
    end
    acc_mplier_c = {sum, mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier with start/busy/done handshake.
// Optional build macro MULT_SIGNED_EN: two's complement operands, sign fixed
// up on completion, overflow against a signed WIDTH-bit result.
module seq_multiplier
  import alu_arith_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  mult_state_t state, state_next;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    product_d;
  logic             overflow_d;
  logic             busy_d, done_d;
  logic [PW-1:0]    step_c;
  logic [PW-1:0]    prod_fin;
  logic             ovf_fin;
  logic [WIDTH-1:0] a_cap, b_cap;

  mult_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc          (acc_q),
    .mplier       (mplier_q),
    .mcand        (mcand_q),
    .acc_mplier_c (step_c)
  );

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Operands enter the unsigned core as magnitudes; the sign is reapplied at the end.
  always_comb begin
    a_cap    = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
    b_cap    = B[WIDTH-1] ? (WIDTH'(0) - B) : B;
    prod_fin = sign_q ? (PW'(0) - step_c) : step_c;
    ovf_fin  = !((&prod_fin[PW-1:WIDTH-1]) || (~|prod_fin[PW-1:WIDTH-1]));
  end
`else
  // Unsigned build: operands and final product pass straight through.
  always_comb begin
    a_cap    = A;
    b_cap    = B;
    prod_fin = step_c;
    ovf_fin  = |prod_fin[PW-1:WIDTH];
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_next = state;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    product_d  = product;
    overflow_d = overflow;
    busy_d     = 1'b0;
    done_d     = 1'b0;
`ifdef MULT_SIGNED_EN
    sign_d     = sign_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          mcand_d    = a_cap;
          mplier_d   = b_cap;
          acc_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
`ifdef MULT_SIGNED_EN
          sign_d     = A[WIDTH-1] ^ B[WIDTH-1];
`endif
        end
      end
      RUN: begin
        {acc_d, mplier_d} = step_c;
        cnt_d             = cnt_q + CNT_W'(1);
        busy_d            = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_next = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          product_d  = prod_fin;
          overflow_d = ovf_fin;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      product  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      product  <= product_d;
      overflow <= overflow_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

endmodule
